vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync driver.
- Timing is fully set by parameters and advanced by a pixel clock-enable, so it runs from the system clock.
- Produces registered hsync, vsync, display enable, pixel coordinates, blanking flags, frame/line strobes and a programmable line-match pulse.
- Sits between the pixel clock-enable divider and the framebuffer/pixel pipeline.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing_gen_if.sv | 45 ++++
 rtl/vga_axis_counter.sv | 49 ++++
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA raster timing generator.
// The colour-bar table is used only when VGA_TIMING_TESTPAT_EN is defined.
package vga_pkg;

    localparam int H_VA_DEFAULT = 640;
    localparam int H_FP_DEFAULT = 16;
    localparam int H_SP_DEFAULT = 96;
    localparam int H_BP_DEFAULT = 48;
    localparam int V_VA_DEFAULT = 480;
    localparam int V_FP_DEFAULT = 10;
    localparam int V_SP_DEFAULT = 2;
    localparam int V_BP_DEFAULT = 33;

    typedef struct packed {
        int unsigned va;
        int unsigned fp;
        int unsigned sp;
        int unsigned bp;
    } vga_timing_t;

    localparam vga_timing_t H_TIMING_DEFAULT = '{
        va: H_VA_DEFAULT, fp: H_FP_DEFAULT, sp: H_SP_DEFAULT, bp: H_BP_DEFAULT
    };

    localparam int NUM_BARS = 8;

    // 4 bits per channel, ordered R,G,B: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [11:0] BAR_COLOURS [NUM_BARS] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    function automatic int unsigned axis_total(input vga_timing_t t);
        return t.va + t.fp + t.sp + t.bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bus: pixel clock-enable and run controls in, sync/blank/coordinate outputs back.
// The rgb signal exists only when VGA_TIMING_TESTPAT_EN is defined.
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           pix_ce;
    logic           en;
    logic [Y_W-1:0] match_line;
    logic           hsync;
    logic           vsync;
    logic           display;
    logic           hblank;
    logic           vblank;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;
    logic           line_match;
`ifdef VGA_TIMING_TESTPAT_EN
    logic [11:0]    rgb;

    modport master (
        input  pix_ce, en, match_line,
        output hsync, vsync, display, hblank, vblank, x, y,
               line_start, frame_start, line_match, rgb
    );
    modport slave (
        output pix_ce, en, match_line,
        input  hsync, vsync, display, hblank, vblank, x, y,
               line_start, frame_start, line_match, rgb
    );
`else
    modport master (
        input  pix_ce, en, match_line,
        output hsync, vsync, display, hblank, vblank, x, y,
               line_start, frame_start, line_match
    );
    modport slave (
        output pix_ce, en, match_line,
        input  hsync, vsync, display, hblank, vblank, x, y,
               line_start, frame_start, line_match
    );
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap/carry plus active and sync region decode.
// Decode outputs reflect the current (pre-increment) count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter vga_timing_t TIM = H_TIMING_DEFAULT,
    parameter int          W   = $clog2(axis_total(TIM))
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce_i,
    input  logic         carry_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam int          TOTAL      = axis_total(TIM);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_END = W'(TIM.va);
    localparam logic [W-1:0] SYNC_LO    = W'(TIM.va + TIM.fp);
    localparam logic [W-1:0] SYNC_HI    = W'(TIM.va + TIM.fp + TIM.sp);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign count_o  = count_q;
    assign wrap_o   = (count_q == LAST);
    assign active_o = (count_q < ACTIVE_END);
    assign sync_o   = (count_q >= SYNC_LO) && (count_q < SYNC_HI);

    // The carry chains the axes: the vertical axis only moves when the horizontal one wraps.
    always_comb begin
        count_d = count_q;
        if (ce_i && carry_i) begin
            count_d = wrap_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator advanced by a pixel clock-enable.
// Define VGA_TIMING_TESTPAT_EN to add an rgb colour-bar test pattern output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VA  = H_VA_DEFAULT,
    parameter int H_FP  = H_FP_DEFAULT,
    parameter int H_SP  = H_SP_DEFAULT,
    parameter int H_BP  = H_BP_DEFAULT,
    parameter int V_VA  = V_VA_DEFAULT,
    parameter int V_FP  = V_FP_DEFAULT,
    parameter int V_SP  = V_SP_DEFAULT,
    parameter int V_BP  = V_BP_DEFAULT,
    parameter int H_POL = 0,
    parameter int V_POL = 0
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master bus
);

    localparam vga_timing_t H_TIM = '{va: H_VA, fp: H_FP, sp: H_SP, bp: H_BP};
    localparam vga_timing_t V_TIM = '{va: V_VA, fp: V_FP, sp: V_SP, bp: V_BP};
    localparam int   H_TOTAL = axis_total(H_TIM);
    localparam int   V_TOTAL = axis_total(V_TIM);
    localparam int   X_W     = $clog2(H_TOTAL);
    localparam int   Y_W     = $clog2(V_TOTAL);
    localparam logic HS_ON   = (H_POL != 0);
    localparam logic VS_ON   = (V_POL != 0);

    if (H_VA == 0 || H_FP == 0 || H_SP == 0 || H_BP == 0 ||
        V_VA == 0 || V_FP == 0 || V_SP == 0 || V_BP == 0) begin : g_bad_timing
        $error("vga_timing_gen: every active, porch and sync length must be non-zero");
    end

    logic           ce;
    logic [X_W-1:0] h;
    logic [Y_W-1:0] v;
    logic           hWrap;
    logic           hActive;
    logic           hSync;
    logic           vActive;
    logic           vSync;
    logic           unused_vwrap;

    logic           hsync_q;
    logic           vsync_q;
    logic           display_q;
    logic           hblank_q;
    logic           vblank_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           line_start_q;
    logic           frame_start_q;
    logic           line_match_q;

    assign ce = bus.pix_ce & bus.en;

    vga_axis_counter #(.TIM(H_TIM), .W(X_W)) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .ce_i     (ce),
        .carry_i  (1'b1),
        .count_o  (h),
        .wrap_o   (hWrap),
        .active_o (hActive),
        .sync_o   (hSync)
    );

    vga_axis_counter #(.TIM(V_TIM), .W(Y_W)) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .ce_i     (ce),
        .carry_i  (hWrap),
        .count_o  (v),
        .wrap_o   (unused_vwrap),
        .active_o (vActive),
        .sync_o   (vSync)
    );

`ifdef VGA_TIMING_TESTPAT_EN
    localparam int BAR_W = (H_VA / NUM_BARS > 0) ? H_VA / NUM_BARS : 1;

    logic [11:0] rgb_q;
    logic [11:0] barColour;
    int          barIdx;

    // Pixels past the eighth full bar width fold into the last (black) bar.
    always_comb begin
        barIdx = int'(h) / BAR_W;
        if (barIdx > NUM_BARS - 1) begin
            barIdx = NUM_BARS - 1;
        end
        barColour = BAR_COLOURS[barIdx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= '0;
        end else if (ce) begin
            rgb_q <= (hActive && vActive) ? barColour : 12'h000;
        end
    end

    assign bus.rgb = rgb_q;
`endif

    // Level outputs follow the counters one ce late; strobes live for a single clk only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            display_q     <= 1'b0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            line_match_q  <= 1'b0;
        end else begin
            line_start_q  <= ce && (h == '0);
            frame_start_q <= ce && (h == '0) && (v == '0);
            line_match_q  <= ce && (h == '0) && (v == bus.match_line);
            if (ce) begin
                hsync_q   <= hSync ? HS_ON : ~HS_ON;
                vsync_q   <= vSync ? VS_ON : ~VS_ON;
                display_q <= hActive && vActive;
                hblank_q  <= ~hActive;
                vblank_q  <= ~vActive;
                x_q       <= h;
                y_q       <= v;
            end
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.display     = display_q;
    assign bus.hblank      = hblank_q;
    assign bus.vblank      = vblank_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.line_match  = line_match_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen on a reduced raster (30x13) so whole frames stay short.
// A pixel-index reference model predicts every output on every clock.
module tb_vga_timing_gen;

    localparam int H_VA = 20, H_FP = 3, H_SP = 4, H_BP = 3;
    localparam int V_VA = 6,  V_FP = 2, V_SP = 2, V_BP = 3;
    localparam int H_POL = 0, V_POL = 1;
    localparam int HT    = H_VA + H_FP + H_SP + H_BP;
    localparam int VT    = V_VA + V_FP + V_SP + V_BP;
    localparam int FRAME = HT * VT;
    localparam int X_W   = $clog2(HT);
    localparam int Y_W   = $clog2(VT);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

    vga_timing_gen #(
        .H_VA(H_VA), .H_FP(H_FP), .H_SP(H_SP), .H_BP(H_BP),
        .V_VA(V_VA), .V_FP(V_FP), .V_SP(V_SP), .V_BP(V_BP),
        .H_POL(H_POL), .V_POL(V_POL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: linear pixel index within the frame plus predicted outputs.
    int          p;
    int          eX, eY;
    logic        eDisp, eHb, eVb, eHs, eVs, eLs, eFs, eLm;
    logic [11:0] eRgb;

    typedef struct {
        logic ce;
        logic en;
        int   ml;
        int   x;
        int   y;
        logic disp;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
        logic lm;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [11:0] barRgb(input int x);
        logic [11:0] bars [8];
        int idx;
        bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        idx = x / (H_VA / 8);
        if (idx > 7) idx = 7;
        return bars[idx];
    endfunction

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        p     = 0;
        eX    = 0;
        eY    = 0;
        eDisp = 1'b0;
        eHb   = 1'b0;
        eVb   = 1'b0;
        eHs   = (H_POL == 0);
        eVs   = (V_POL == 0);
        eLs   = 1'b0;
        eFs   = 1'b0;
        eLm   = 1'b0;
        eRgb  = 12'h000;
    endtask

    task automatic modelClock(input logic ce, input logic en, input int ml);
        int x;
        int y;
        x   = p % HT;
        y   = p / HT;
        eLs = 1'b0;
        eFs = 1'b0;
        eLm = 1'b0;
        if (ce && en) begin
            eX    = x;
            eY    = y;
            eDisp = (x < H_VA) && (y < V_VA);
            eHb   = (x >= H_VA);
            eVb   = (y >= V_VA);
            eHs   = (x >= H_VA + H_FP && x < H_VA + H_FP + H_SP) ? (H_POL != 0) : (H_POL == 0);
            eVs   = (y >= V_VA + V_FP && y < V_VA + V_FP + V_SP) ? (V_POL != 0) : (V_POL == 0);
            eLs   = (x == 0);
            eFs   = (p == 0);
            eLm   = (x == 0) && (y == ml);
            eRgb  = eDisp ? barRgb(x) : 12'h000;
            p     = (p + 1) % FRAME;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".x"},           16'(bus.x),           16'(eX));
        checkVal({tag, ".y"},           16'(bus.y),           16'(eY));
        checkVal({tag, ".display"},     16'(bus.display),     16'(eDisp));
        checkVal({tag, ".hblank"},      16'(bus.hblank),      16'(eHb));
        checkVal({tag, ".vblank"},      16'(bus.vblank),      16'(eVb));
        checkVal({tag, ".hsync"},       16'(bus.hsync),       16'(eHs));
        checkVal({tag, ".vsync"},       16'(bus.vsync),       16'(eVs));
        checkVal({tag, ".line_start"},  16'(bus.line_start),  16'(eLs));
        checkVal({tag, ".frame_start"}, 16'(bus.frame_start), 16'(eFs));
        checkVal({tag, ".line_match"},  16'(bus.line_match),  16'(eLm));
`ifdef VGA_TIMING_TESTPAT_EN
        checkVal({tag, ".rgb"},         16'(bus.rgb),         16'(eRgb));
`endif
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 ns later.
    task automatic applyStimulus(input logic ce, input logic en, input int ml, input string tag);
        @(negedge clk);
        bus.pix_ce     = ce;
        bus.en         = en;
        bus.match_line = Y_W'(ml);
        @(posedge clk);
        if (rst) modelClock(ce, en, ml);
        else     modelReset();
        #1;
        checkOutput(tag);
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got time limit, expected end of test (%0d checks, %0d errors)",
                 checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int found;
        int last;
        int lastLs;
        int cnt;
        int savedX;
        int savedY;
        int bound;

        vecs[0] = '{ce: 0, en: 1, ml: 0, x: 0, y: 0, disp: 0, hs: 1, vs: 0, ls: 0, fs: 0, lm: 0};
        vecs[1] = '{ce: 1, en: 1, ml: 0, x: 0, y: 0, disp: 1, hs: 1, vs: 0, ls: 1, fs: 1, lm: 1};
        vecs[2] = '{ce: 1, en: 1, ml: 0, x: 1, y: 0, disp: 1, hs: 1, vs: 0, ls: 0, fs: 0, lm: 0};
        vecs[3] = '{ce: 0, en: 1, ml: 0, x: 1, y: 0, disp: 1, hs: 1, vs: 0, ls: 0, fs: 0, lm: 0};
        vecs[4] = '{ce: 1, en: 0, ml: 0, x: 1, y: 0, disp: 1, hs: 1, vs: 0, ls: 0, fs: 0, lm: 0};
        vecs[5] = '{ce: 1, en: 1, ml: 0, x: 2, y: 0, disp: 1, hs: 1, vs: 0, ls: 0, fs: 0, lm: 0};
        vecs[6] = '{ce: 1, en: 1, ml: 5, x: 3, y: 0, disp: 1, hs: 1, vs: 0, ls: 0, fs: 0, lm: 0};

        rst            = 1'b0;
        bus.pix_ce     = 1'b0;
        bus.en         = 1'b0;
        bus.match_line = '0;
        modelReset();
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("reset");
        end
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].ce, vecs[i].en, vecs[i].ml, "table");
            checkVal("table.x",           16'(bus.x),           16'(vecs[i].x));
            checkVal("table.y",           16'(bus.y),           16'(vecs[i].y));
            checkVal("table.display",     16'(bus.display),     16'(vecs[i].disp));
            checkVal("table.hsync",       16'(bus.hsync),       16'(vecs[i].hs));
            checkVal("table.vsync",       16'(bus.vsync),       16'(vecs[i].vs));
            checkVal("table.line_start",  16'(bus.line_start),  16'(vecs[i].ls));
            checkVal("table.frame_start", 16'(bus.frame_start), 16'(vecs[i].fs));
            checkVal("table.line_match",  16'(bus.line_match),  16'(vecs[i].lm));
        end

        $display("[TB] frame and line periods with pix_ce held high");
        found  = 0;
        last   = 0;
        lastLs = -1;
        for (int i = 0; i < 3 * FRAME && found < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 0, "frame");
            if (bus.line_start) begin
                if (lastLs >= 0) checkVal("line.period", 16'(i - lastLs), 16'(HT));
                lastLs = i;
            end
            if (bus.frame_start) begin
                if (found > 0) checkVal("frame.period", 16'(i - last), 16'(FRAME));
                last = i;
                found++;
            end
        end
        if (found < 2) timeoutFail("frame.period");

        $display("[TB] line_match in range and out of range");
        cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b1, 1'b1, 3, "match3");
            if (bus.line_match) begin
                cnt++;
                checkVal("match3.x", 16'(bus.x), 16'd0);
                checkVal("match3.y", 16'(bus.y), 16'd3);
            end
        end
        checkVal("match3.count", 16'(cnt), 16'd1);
        cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b1, 1'b1, 14, "match14");
            if (bus.line_match) cnt++;
        end
        checkVal("match14.count", 16'(cnt), 16'd0);

        $display("[TB] 1-in-4 pix_ce with en low mid-line");
        bound = 0;
        while (!(eX == 10) && bound < 4 * FRAME) begin
            applyStimulus(bound % 4 == 0, 1'b1, 0, "ce4");
            bound++;
        end
        if (bound >= 4 * FRAME) timeoutFail("ce4.reach_x10");
        savedX = eX;
        savedY = eY;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(i % 4 == 0, 1'b0, 0, "enlow");
            checkVal("enlow.hold_x", 16'(bus.x), 16'(savedX));
            checkVal("enlow.hold_y", 16'(bus.y), 16'(savedY));
        end
        applyStimulus(1'b0, 1'b1, 0, "resume_idle");
        applyStimulus(1'b1, 1'b1, 0, "resume");
        checkVal("resume.x", 16'(bus.x), 16'(savedX + 1));
        checkVal("resume.y", 16'(bus.y), 16'(savedY));

        $display("[TB] asynchronous reset mid-frame");
        bound = 0;
        while (!(eX == 10 && eY == 4) && bound < 2 * FRAME) begin
            applyStimulus(1'b1, 1'b1, 0, "seek");
            bound++;
        end
        if (bound >= 2 * FRAME) timeoutFail("seek.reach_10_4");
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncrst");
        checkVal("asyncrst.hsync", 16'(bus.hsync), 16'd1);
        checkVal("asyncrst.x", 16'(bus.x), 16'd0);
        applyStimulus(1'b1, 1'b1, 0, "inrst");
        applyStimulus(1'b0, 1'b1, 0, "inrst");
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 0, "restart");
        checkVal("restart.frame_start", 16'(bus.frame_start), 16'd1);
        checkVal("restart.display", 16'(bus.display), 16'd1);
        applyStimulus(1'b1, 1'b1, 0, "restart");
        checkVal("restart.x1", 16'(bus.x), 16'd1);

        $display("[TB] randomized stimulus");
        for (int i = 0; i < 5000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
                          int'($urandom_range(0, 15)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
